// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: paces pixel fetch by col/row, shifts six colour bits
// into the panel, then latches the row and shows it for ON_CYCLES cycles.
module hub75_scan_ctrl #(
  parameter int COLS      = 64,
  parameter int HALF_ROWS = 16,
  parameter int ON_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  output logic [$clog2(COLS)-1:0]      col,
  output logic [$clog2(HALF_ROWS)-1:0] row,
  input  logic                         R0in,
  input  logic                         G0in,
  input  logic                         B0in,
  input  logic                         R1in,
  input  logic                         G1in,
  input  logic                         B1in,
  output logic                         pan_r0,
  output logic                         pan_g0,
  output logic                         pan_b0,
  output logic                         pan_r1,
  output logic                         pan_g1,
  output logic                         pan_b1,
  output logic                         pan_clk,
  output logic                         pan_lat,
  output logic                         pan_oe_n,
  output logic [$clog2(HALF_ROWS)-1:0] pan_addr,
  output logic                         frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(HALF_ROWS);
  localparam int OW = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PREP     = 3'd1;
  localparam logic [2:0] S_SHIFT_LO = 3'd2;
  localparam logic [2:0] S_SHIFT_HI = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;
  localparam logic [2:0] S_DISPLAY  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] pix_q, pix_d;
  logic [RW-1:0] row_q, row_d;
  logic [RW-1:0] addr_q, addr_d;
  logic [OW-1:0] on_q, on_d;
  logic [5:0]    dat_q, dat_d;
  logic          fd_q, fd_d;
  logic [5:0]    in_bits;

  assign in_bits = {R0in, G0in, B0in, R1in, G1in, B1in};

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pix_d   = pix_q;
    row_d   = row_q;
    addr_d  = addr_q;
    on_d    = on_q;
    dat_d   = dat_q;
    fd_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        col_d = '0;
        row_d = '0;
        if (enable) state_d = S_PREP;
      end
      S_PREP: begin
        dat_d   = in_bits;
        col_d   = CW'(1);
        pix_d   = '0;
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: state_d = S_SHIFT_HI;
      S_SHIFT_HI: begin
        // col runs one ahead of pix so the driver has two cycles per pixel
        if (pix_q == CW'(COLS - 1)) begin
          col_d   = '0;
          state_d = S_LATCH;
        end else begin
          dat_d   = in_bits;
          col_d   = col_q + CW'(1);
          pix_d   = pix_q + CW'(1);
          state_d = S_SHIFT_LO;
        end
      end
      S_LATCH: begin
        addr_d  = row_q;
        on_d    = '0;
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (on_q == OW'(ON_CYCLES - 1)) begin
          fd_d  = (row_q == RW'(HALF_ROWS - 1));
          row_d = (row_q == RW'(HALF_ROWS - 1)) ? '0 : row_q + RW'(1);
          if (enable) begin
            state_d = S_PREP;
          end else begin
            state_d = S_IDLE;
            row_d   = '0;
          end
        end else begin
          on_d = on_q + OW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      pix_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      on_q    <= '0;
      dat_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      on_q    <= on_d;
      dat_q   <= dat_d;
      fd_q    <= fd_d;
    end
  end

  assign col        = col_q;
  assign row        = row_q;
  assign pan_addr   = addr_q;
  assign frame_done = fd_q;
  assign {pan_r0, pan_g0, pan_b0, pan_r1, pan_g1, pan_b1} = dat_q;

  // Strobes decode straight from the state register, so lat and OE never overlap
  assign pan_clk  = (state_q == S_SHIFT_HI);
  assign pan_lat  = (state_q == S_LATCH);
  assign pan_oe_n = (state_q != S_DISPLAY);

endmodule
